// File: rtl/pe_array_sched_pkg.sv
// pe_sched_pkg: shared states, operand width and the bit-reversal used for randW.
package pe_sched_pkg;
  localparam int IWIDTH = 8;
  localparam int LW = IWIDTH - 1;
  localparam int MAXLEN = 1 << LW;
  typedef enum logic [2:0] {IDLE, CLR, LOADW, COMP, DRAIN, FIN, ABRT} state_t;
  function automatic logic [LW-1:0] bitrev(input logic [LW-1:0] v);
    for (int i = 0; i < LW; i++) bitrev[i] = v[LW-1-i];
  endfunction
endpackage

// File: rtl/pe_array_sched_if.sv
// pe_array_sched_if: host job request/config and PE-array edge controls.
interface pe_array_sched_if #(parameter int KW = 8);
  import pe_sched_pkg::*;
  logic start, abort;
  logic [KW-1:0] cfg_k;
  logic [LW-1:0] cfg_len;
  logic busy, done, en_w, clr_w, en_i, clr_i, en_o, clr_o, mac_done;
  logic [LW-1:0] randW;
  modport master(output start, abort, cfg_k, cfg_len,
                 input busy, done, en_w, clr_w, en_i, clr_i, en_o, clr_o, mac_done, randW);
  modport slave(input start, abort, cfg_k, cfg_len,
                output busy, done, en_w, clr_w, en_i, clr_i, en_o, clr_o, mac_done, randW);
endinterface

// File: rtl/pe_array_sched_rng_bitrev.sv
// rng_bitrev: stream-cycle up-counter whose bit-reversed value is the weight comparison number.
module rng_bitrev
  import pe_sched_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [LW-1:0] rnd
);
  logic [LW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign rnd = bitrev(cnt);
endmodule

// File: rtl/pe_array_sched.sv
// pe_array_sched: per-job sequencer (clear, weight load, K unary steps, drain) for the PE array edge.
// Outputs are registered decodes of the current state, so they trail the state by one cycle.
module pe_array_sched
  import pe_sched_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int KW   = 8
) (
  input logic               clk,
  input logic               rst,
  pe_array_sched_if.slave   bus
);
  localparam int DRN = ROWS + COLS;
  localparam int PW = $clog2(DRN > MAXLEN ? DRN : MAXLEN);
  state_t state, nxt;
  logic [PW-1:0] cnt, last;
  logic [KW-1:0] k, k_cfg;
  logic [IWIDTH-1:0] len;
  logic [LW-1:0] rnd;
  logic phase_end, acc;
  rng_bitrev u_rng (.clk(clk), .rst(rst), .clr(state != COMP), .en(state == COMP), .rnd(rnd));
  always_comb begin
    last = state == LOADW ? PW'(ROWS - 1) : state == COMP ? PW'(len - 1'b1) :
           state == DRAIN ? PW'(DRN - 1) : '0;
    phase_end = cnt == last;
    acc = state == IDLE && bus.start && !bus.abort;
    nxt = state;
    if (state == IDLE) nxt = acc ? (bus.cfg_k == '0 ? FIN : CLR) : IDLE;
    else if (bus.abort && state inside {CLR, LOADW, COMP, DRAIN}) nxt = ABRT;
    else if (state == CLR) nxt = LOADW;
    else if (state inside {FIN, ABRT}) nxt = IDLE;
    else if (phase_end)
      nxt = state == LOADW ? COMP : state == DRAIN ? FIN : k == k_cfg - 1'b1 ? DRAIN : LOADW;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      k <= '0;
      k_cfg <= '0;
      len <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.en_w <= 1'b0;
      bus.clr_w <= 1'b0;
      bus.en_i <= 1'b0;
      bus.clr_i <= 1'b0;
      bus.en_o <= 1'b0;
      bus.clr_o <= 1'b0;
      bus.mac_done <= 1'b0;
      bus.randW <= '0;
    end else begin
      state <= nxt;
      cnt <= (nxt != state || state == IDLE) ? '0 : cnt + 1'b1;
      if (acc) begin
        k_cfg <= bus.cfg_k;
        len <= bus.cfg_len == '0 ? IWIDTH'(MAXLEN) : {1'b0, bus.cfg_len};
      end
      if (state == CLR) k <= '0;
      else if (state == COMP && phase_end) k <= k + 1'b1;
      bus.busy <= !(state inside {IDLE, ABRT});
      bus.done <= state == FIN;
      bus.en_w <= state == LOADW;
      bus.clr_w <= state inside {CLR, ABRT};
      bus.en_i <= state == COMP;
      bus.clr_i <= state inside {CLR, ABRT};
      bus.en_o <= state inside {COMP, DRAIN};
      bus.clr_o <= state inside {CLR, ABRT};
      bus.mac_done <= state == COMP && phase_end;
      bus.randW <= state == COMP ? rnd : '0;
    end
  end
endmodule

// File: tb/tb_pe_array_sched.sv
// tb_pe_array_sched: job-schedule reference model compared every cycle, plus directed count checks.
module tb_pe_array_sched;
  import pe_sched_pkg::*;
  localparam int ROWS = 8, COLS = 8;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  pe_array_sched_if #(.KW(8)) bus();
  pe_array_sched #(.ROWS(ROWS), .COLS(COLS), .KW(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [15:0] exp_q[$];
  int tag_q[$];
  int vectors = 0, miscompares = 0, cyc = 0;
  bit chk_en = 1'b0;
  int busy_cnt, enw_cnt, eni_cnt, eno_cnt, clr_cnt, mac_cnt, done_cnt, done_cyc, mac_idx, start_cyc;
  int rw_q[$];
  logic [15:0] got, want;

  function automatic int rev7(int j);
    int r = 0;
    for (int i = 0; i < 7; i++) r = (r << 1) | ((j >> i) & 1);
    return r;
  endfunction

  // packing: busy,done,en_w,clr_w,en_i,clr_i,en_o,clr_o,mac_done,randW[6:0]
  function automatic logic [15:0] mk(bit b, bit d, bit ew, bit c, bit ei, bit eo, bit md, int rw);
    return {b, d, ew, c, ei, c, eo, c, md, 7'(rw)};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {bus.busy, bus.done, bus.en_w, bus.clr_w, bus.en_i, bus.clr_i,
            bus.en_o, bus.clr_o, bus.mac_done, bus.randW};
  endfunction

  task automatic push(logic [15:0] v, int t);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  // tags: 0 idle, 1 clear, 2 weight load, 3 stream, 4 drain, 5 finish, 6 abort clear
  task automatic push_job(int kk, int ln);
    push('0, 0);
    if (kk != 0) begin
      push(mk(1, 0, 0, 1, 0, 0, 0, 0), 1);
      for (int s = 0; s < kk; s++) begin
        for (int r = 0; r < ROWS; r++) push(mk(1, 0, 1, 0, 0, 0, 0, 0), 2);
        for (int j = 0; j < ln; j++) push(mk(1, 0, 0, 0, 1, 1, j == ln - 1, rev7(j)), 3);
      end
      for (int r = 0; r < ROWS + COLS; r++) push(mk(1, 0, 0, 0, 0, 1, 0, 0), 4);
    end
    push(mk(1, 1, 0, 0, 0, 0, 0, 0), 5);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      tag_q.delete();
    end else begin
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(tag_q.pop_front());
      end
      if (bus.abort && tag_q.size() > 0 && tag_q[0] >= 1 && tag_q[0] <= 4) begin
        while (exp_q.size() > 1) begin
          void'(exp_q.pop_back());
          void'(tag_q.pop_back());
        end
        push(mk(0, 0, 0, 1, 0, 0, 0, 0), 6);
      end else if (exp_q.size() == 0 && bus.start && !bus.abort)
        push_job(int'(bus.cfg_k), bus.cfg_len == '0 ? 128 : int'(bus.cfg_len));
    end
  end

  always @(negedge clk) if (chk_en) begin
    cyc++;
    got = dut_vec();
    want = exp_q.size() > 0 ? exp_q[0] : '0;
    vectors++;
    if (got !== want) begin
      miscompares++;
      if (miscompares <= 20) $display("FAIL outputs cycle %0d: got %h want %h", cyc, got, want);
    end
    busy_cnt += int'(bus.busy);
    enw_cnt += int'(bus.en_w);
    eno_cnt += int'(bus.en_o);
    clr_cnt += int'(bus.clr_w);
    mac_cnt += int'(bus.mac_done);
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.en_i) begin
      if (bus.mac_done) mac_idx = eni_cnt;
      rw_q.push_back(int'(bus.randW));
      eni_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(string n, int act, int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", n, act, exp_v);
    end
  endtask

  task automatic clr_stats();
    busy_cnt = 0; enw_cnt = 0; eni_cnt = 0; eno_cnt = 0; clr_cnt = 0;
    mac_cnt = 0; done_cnt = 0; done_cyc = -1; mac_idx = -1;
    rw_q.delete();
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL idle_timeout: still busy after %0d cycles, want idle", n);
    end
  endtask

  task automatic pulse_start(int kk, int ln);
    bus.cfg_k = 8'(kk);
    bus.cfg_len = 7'(ln);
    bus.start = 1'b1;
    start_cyc = cyc + 1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_en_i(string n);
    int m = 0;
    while (!bus.en_i && m < 100) begin
      tick();
      m++;
    end
    chk(n, int'(bus.en_i), 1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.cfg_k = '0;
    bus.cfg_len = '0;
    clr_stats();
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_outputs", int'(dut_vec()), 0);
    // k=2, len=4: 1 + 2*(8+4) + 16 + 1 = 42 busy cycles
    clr_stats();
    pulse_start(2, 4);
    wait_idle(500);
    chk("job_a_busy", busy_cnt, 42);
    chk("job_a_en_w", enw_cnt, 16);
    chk("job_a_mac_done", mac_cnt, 2);
    chk("job_a_done", done_cnt, 1);
    chk("job_a_clr", clr_cnt, 1);
    // len=0 means a 128-cycle stream
    clr_stats();
    pulse_start(1, 0);
    wait_idle(1000);
    chk("len0_en_i", eni_cnt, 128);
    chk("len0_rw0", rw_q.size() > 4 ? rw_q[0] : -1, 0);
    chk("len0_rw1", rw_q.size() > 4 ? rw_q[1] : -1, 64);
    chk("len0_rw2", rw_q.size() > 4 ? rw_q[2] : -1, 32);
    chk("len0_rw3", rw_q.size() > 4 ? rw_q[3] : -1, 96);
    chk("len0_rw4", rw_q.size() > 4 ? rw_q[4] : -1, 16);
    chk("len0_mac_idx", mac_idx, 127);
    // empty job
    clr_stats();
    pulse_start(0, 5);
    wait_idle(50);
    chk("k0_done_delay", done_cyc - start_cyc, 2);
    chk("k0_no_pulses", enw_cnt + eni_cnt + eno_cnt + clr_cnt, 0);
    chk("k0_busy", busy_cnt, 1);
    // abort in COMP, then restart during the clear cycle
    clr_stats();
    pulse_start(3, 5);
    wait_en_i("abort_reach_comp");
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    tick();
    pulse_start(1, 2);
    chk("abort_clr_pulses", clr_cnt, 2);
    chk("abort_no_done", done_cnt, 0);
    wait_idle(200);
    chk("abort_restart_done", done_cnt, 1);
    // start while busy is dropped
    clr_stats();
    pulse_start(1, 3);
    repeat (5) tick();
    pulse_start(2, 9);
    wait_idle(300);
    chk("busy_start_len", busy_cnt, 29);
    chk("busy_start_done", done_cnt, 1);
    chk("busy_start_mac", mac_cnt, 1);
    // reset in the middle of a stream
    clr_stats();
    pulse_start(1, 20);
    wait_en_i("rst_reach_comp");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_mid_comp", int'(dut_vec()), 0);
    clr_stats();
    pulse_start(0, 0);
    wait_idle(50);
    chk("after_reset_done", done_cnt, 1);
    for (int c = 0; c < 5000; c++) begin
      rst = $urandom_range(0, 799) == 0;
      bus.start = $urandom_range(0, 7) == 0;
      bus.abort = $urandom_range(0, 149) == 0;
      bus.cfg_k = 8'($urandom_range(0, 3));
      bus.cfg_len = $urandom_range(0, 9) == 0 ? 7'd0 : 7'($urandom_range(1, 12));
      tick();
    end
    rst = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    wait_idle(2000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
